writeback: RTL and testbench
============================

# writeback

Final stage of the rv32 core, directly downstream of the memory stage. It consumes the memory stage's registered outputs (decoded control, rd address, ALU result, registered load word, PC, PC+4), selects and formats the write-back value, commits it to the 32x32 integer register file it owns, and serves the decode stage's two combinational read ports with same-cycle write bypass. It also keeps a registered forwarding record, a retired-instruction counter and a misaligned-load flag.

## Interface
- CountWidth, 64, width of the retired-instruction counter
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  an instruction occupies the stage this cycle
- reg_write_i  in  1  instruction writes rd
- wb_sel_i  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- load_funct3_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other code treated as LW
- addr_rd_i  in  5  destination register
- alu_i  in  32  ALU result; bits [1:0] are the load byte offset
- dmem_i  in  32  registered word read from data memory
- pc_i  in  32  PC of the instruction
- pc_plus4_i  in  32  PC+4 of the instruction
- rs1_addr_i, rs2_addr_i  in  5 each  decode-stage read addresses
- rs1_data_o, rs2_data_o  out  32 each  combinational read data
- fwd_we_o  out  1  registered: a register was written last cycle
- fwd_rd_o  out  5  registered rd of that write
- fwd_data_o  out  32  registered value of that write
- retired_o  out  CountWidth  count of instructions retired
- last_pc_o  out  32  PC of the most recently retired instruction
- misalign_o  out  1  registered one-cycle pulse for a misaligned load

## Operation
- Load formatting with off = alu_i[1:0]:
  - LB/LBU: byte dmem_i[8*off +: 8], sign- or zero-extended.
  - LH/LHU: half dmem_i[16*off[1] +: 16], sign- or zero-extended.
  - LW: dmem_i unchanged.
- Misaligned load: valid_i, wb_sel_i=01, and either a halfword with off[0]=1 or a word with off!=0.
  - The register write is suppressed.
  - misalign_o pulses the next cycle.
  - The instruction still counts as retired.
- wb_val = ALU / formatted load / PC+4, per wb_sel_i.
- we = valid_i & reg_write_i & (addr_rd_i!=0) & !misaligned.
- Register file:
  - x0 is hard-wired to 0 and is never written.
  - When we=1, regs[addr_rd_i] <= wb_val.
- Read ports:
  - An address of 0 returns 0.
  - If the address equals addr_rd_i and we=1, the port returns wb_val (bypass).
  - Otherwise the port returns the stored register.
- Forwarding record, every cycle: fwd_we_o <= we, fwd_rd_o <= addr_rd_i, fwd_data_o <= wb_val. fwd_rd_o and fwd_data_o are only meaningful when fwd_we_o=1.
- Retire, when valid_i=1:
  - retired_o <= retired_o+1, wrapping from all-ones to 0.
  - last_pc_o <= pc_i.
- valid_i=0: no write, no counter change, fwd_we_o <= 0, misalign_o <= 0.

## Timing
- Reset (rst_i=1 at an edge):
  - All 31 registers, retired_o, last_pc_o, the fwd_* outputs and misalign_o are cleared to 0.
  - Any write or retire presented in the reset cycle is discarded, including when reset is asserted mid-stream.
- Write latency: the value is stored at the edge ending the write cycle and is visible through the stored path from the next cycle.
- Same-cycle visibility is provided only by the bypass.
- The read ports are purely combinational from rs*_addr_i and the current inputs, with no register in the path.
- The fwd_*, retired_o, last_pc_o and misalign_o outputs all lag their causing input by exactly one cycle.
- A write and a read to the same register in the same cycle return the new value. A read in the following cycle returns the same value from storage.
- Two instructions to the same rd on consecutive cycles: the later one wins, and the bypass always reflects the current input.

## Test plan
- **Reset:** write x5=0x1234 with rst_i=1 -> rs1_data_o(x5)=0, retired_o=0, fwd_we_o=0 after the edge.
- **Loads:** dmem_i=0x80F17F02. LB with off=3 -> 0xFFFFFF80; LBU with off=3 -> 0x00000080; LH with off=2 -> 0xFFFF80F1; LHU with off=0 -> 0x00007F02; LW -> 0x80F17F02.
- **x0 and bypass:**
  - Write x0=0xDEAD -> reads of x0 return 0 and fwd_we_o=0.
  - Write x7=0xA5A5A5A5 while rs2_addr_i=7 -> rs2_data_o=0xA5A5A5A5 in the same cycle.
  - Next cycle -> fwd_we_o=1, fwd_rd_o=7, fwd_data_o=0xA5A5A5A5.
- **Misaligned:** LW with off=2 to x9 (x9 previously 0x11) -> x9 stays 0x11, misalign_o=1 for one cycle, retired_o increments.
- **PC+4 select:** wb_sel_i=10, pc_i=0x100, pc_plus4_i=0x104 to x1 -> x1=0x104 and last_pc_o=0x100.
- **Counter wrap:** CountWidth=4, 17 valid cycles with valid_i toggled off in between -> retired_o goes 15 then 0, and is unchanged on valid_i=0 cycles.

Source files
------------

// File: rtl/writeback.sv
// writeback: final stage of the rv32 core.
//
// Formats the memory stage's result (ALU, load, or PC+4) and commits it to
// the 32x32 integer register file it owns. It serves two combinational decode
// read ports, with a same-cycle bypass from the write in flight. It also keeps
// a registered forwarding record, a retired-instruction counter, the PC of the
// last retired instruction, and a one-cycle misaligned-load pulse.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   valid_i                   an instruction occupies the stage
//   reg_write_i               instruction writes rd
//   wb_sel_i                  00 ALU, 01 load, 10 PC+4, 11 ALU
//   load_funct3_i             LB/LH/LW/LBU/LHU; other codes behave as LW
//   addr_rd_i                 destination register
//   alu_i                     ALU result; [1:0] is the load byte offset
//   dmem_i                    registered data-memory word
//   pc_i, pc_plus4_i          PC and PC+4 of the instruction
//   rs1/rs2_addr_i, _data_o   combinational read ports
//   fwd_we_o/rd_o/data_o      registered record of last cycle's write
//   retired_o                 retired-instruction count (wraps)
//   last_pc_o                 PC of most recently retired instruction
//   misalign_o                registered misaligned-load pulse
module writeback #(
    parameter int CountWidth = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  reg_write_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [2:0]            load_funct3_i,
    input  logic [4:0]            addr_rd_i,
    input  logic [31:0]           alu_i,
    input  logic [31:0]           dmem_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           pc_plus4_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic [31:0]           rs1_data_o,
    output logic [31:0]           rs2_data_o,
    output logic                  fwd_we_o,
    output logic [4:0]            fwd_rd_o,
    output logic [31:0]           fwd_data_o,
    output logic [CountWidth-1:0] retired_o,
    output logic [31:0]           last_pc_o,
    output logic                  misalign_o
);

    // Extract and extend the addressed byte/half of the loaded word.
    function automatic logic [31:0] format_load(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic signed [7:0]  b_sel;
        logic signed [15:0] h_sel;
        logic [31:0]        res;
        case (off)
            2'd0:    b_sel = word[7:0];
            2'd1:    b_sel = word[15:8];
            2'd2:    b_sel = word[23:16];
            default: b_sel = word[31:24];
        endcase
        h_sel = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res = 32'(b_sel);               // LB: sign-extend
            3'b001:  res = 32'(h_sel);               // LH: sign-extend
            3'b100:  res = {24'd0, b_sel};           // LBU
            3'b101:  res = {16'd0, h_sel};           // LHU
            default: res = word;                     // LW and unknown codes
        endcase
        return res;
    endfunction

    // Halfwords need even offsets, words need offset 0; bytes are always fine.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic res;
        case (funct3)
            3'b000, 3'b100: res = 1'b0;
            3'b001, 3'b101: res = off[0];
            default:        res = (off != 2'd0);
        endcase
        return res;
    endfunction

    logic [31:0]           regs_q [1:31];
    logic                  fwd_we_q;
    logic [4:0]            fwd_rd_q;
    logic [31:0]           fwd_data_q;
    logic [CountWidth-1:0] retired_q;
    logic [CountWidth-1:0] retired_d;
    logic [31:0]           last_pc_q;
    logic                  misalign_q;

    logic [31:0] load_val;
    logic [31:0] wb_val;
    logic        misaligned;
    logic        we;

    // Result selection and write enable
    always_comb begin
        load_val   = format_load(load_funct3_i, alu_i[1:0], dmem_i);
        misaligned = valid_i && (wb_sel_i == 2'b01) &&
                     is_misaligned(load_funct3_i, alu_i[1:0]);
        case (wb_sel_i)
            2'b01:   wb_val = load_val;
            2'b10:   wb_val = pc_plus4_i;
            default: wb_val = alu_i;
        endcase
        we        = valid_i && reg_write_i && (addr_rd_i != 5'd0) && !misaligned;
        retired_d = retired_q + {{(CountWidth-1){1'b0}}, 1'b1};
    end

    // Read ports: x0 first, then bypass of the write in flight, then storage.
    always_comb begin
        rs1_data_o = 32'd0;
        rs2_data_o = 32'd0;
        if (rs1_addr_i != 5'd0) begin
            if (we && (rs1_addr_i == addr_rd_i)) rs1_data_o = wb_val;
            else                                 rs1_data_o = regs_q[rs1_addr_i];
        end
        if (rs2_addr_i != 5'd0) begin
            if (we && (rs2_addr_i == addr_rd_i)) rs2_data_o = wb_val;
            else                                 rs2_data_o = regs_q[rs2_addr_i];
        end
    end

    // Commit stage: register file and registered status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
            fwd_we_q   <= 1'b0;
            fwd_rd_q   <= 5'd0;
            fwd_data_q <= 32'd0;
            retired_q  <= '0;
            last_pc_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (we) regs_q[addr_rd_i] <= wb_val;
            fwd_we_q   <= we;
            fwd_rd_q   <= addr_rd_i;
            fwd_data_q <= wb_val;
            misalign_q <= misaligned;
            if (valid_i) begin
                retired_q <= retired_d;
                last_pc_q <= pc_i;
            end
        end
    end

    assign fwd_we_o   = fwd_we_q;
    assign fwd_rd_o   = fwd_rd_q;
    assign fwd_data_o = fwd_data_q;
    assign retired_o  = retired_q;
    assign last_pc_o  = last_pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid, reg_write;
    logic [1:0]    wb_sel;
    logic [2:0]    funct3;
    logic [4:0]    addr_rd;
    logic [31:0]   alu, dmem, pc, pc_plus4;
    logic [4:0]    rs1_addr, rs2_addr;
    logic [31:0]   rs1_data, rs2_data;
    logic          fwd_we;
    logic [4:0]    fwd_rd;
    logic [31:0]   fwd_data;
    logic [CW-1:0] retired;
    logic [31:0]   last_pc;
    logic          misalign;

    int n_vec = 0;
    int n_err = 0;
    int exp_ret;

    writeback #(.CountWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .reg_write_i(reg_write),
        .wb_sel_i(wb_sel), .load_funct3_i(funct3), .addr_rd_i(addr_rd),
        .alu_i(alu), .dmem_i(dmem), .pc_i(pc), .pc_plus4_i(pc_plus4),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .fwd_we_o(fwd_we), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
        .retired_o(retired), .last_pc_o(last_pc), .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; reg_write = 1'b0; wb_sel = 2'b00; funct3 = 3'b010;
        addr_rd = 5'd0; alu = 32'd0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [31:0] a);
        valid = 1'b1; reg_write = 1'b1; wb_sel = sel; funct3 = f3;
        addr_rd = rd; alu = a;
    endtask

    initial begin
        rst = 1'b1; idle(); dmem = 32'd0; pc = 32'd0; pc_plus4 = 32'd4;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset discards an in-flight write and clears stored state
        wr(5'd5, 2'b00, 3'b010, 32'h1111); pc = 32'h40;
        tick();
        rst = 1'b1; wr(5'd5, 2'b00, 3'b010, 32'h1234);
        tick();
        rst = 1'b0; idle(); rs1_addr = 5'd5;
        #1;
        chk("rst_x5", rs1_data, 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_fwd_we", 32'(fwd_we), 32'h0);
        chk("rst_last_pc", last_pc, 32'h0);
        exp_ret = 0;

        // Load formatting, checked through the bypass then from storage
        dmem = 32'h80F17F02;
        wr(5'd10, 2'b01, 3'b000, 32'h3); rs1_addr = 5'd10; #1;
        chk("lb_off3", rs1_data, 32'hFFFFFF80); tick();
        wr(5'd11, 2'b01, 3'b100, 32'h3); rs1_addr = 5'd11; #1;
        chk("lbu_off3", rs1_data, 32'h00000080); tick();
        wr(5'd12, 2'b01, 3'b001, 32'h2); rs1_addr = 5'd12; #1;
        chk("lh_off2", rs1_data, 32'hFFFF80F1); tick();
        wr(5'd13, 2'b01, 3'b101, 32'h0); rs1_addr = 5'd13; #1;
        chk("lhu_off0", rs1_data, 32'h00007F02); tick();
        wr(5'd14, 2'b01, 3'b010, 32'h0); rs1_addr = 5'd14; #1;
        chk("lw", rs1_data, 32'h80F17F02); tick();
        idle(); rs1_addr = 5'd10; rs2_addr = 5'd12; #1;
        chk("st_x10", rs1_data, 32'hFFFFFF80);
        chk("st_x12", rs2_data, 32'hFFFF80F1);
        chk("ret_loads", 32'(retired), 32'd5);

        // x0 is never written
        wr(5'd0, 2'b00, 3'b010, 32'hDEAD); rs1_addr = 5'd0; #1;
        chk("x0_bypass", rs1_data, 32'h0);
        tick();
        chk("x0_fwd_we", 32'(fwd_we), 32'h0);

        // Same-cycle bypass and forwarding record
        wr(5'd7, 2'b00, 3'b010, 32'hA5A5A5A5); rs2_addr = 5'd7; #1;
        chk("byp_x7", rs2_data, 32'hA5A5A5A5);
        tick();
        idle(); #1;
        chk("fwd_we", 32'(fwd_we), 32'h1);
        chk("fwd_rd", 32'(fwd_rd), 32'd7);
        chk("fwd_data", fwd_data, 32'hA5A5A5A5);
        chk("st_x7", rs2_data, 32'hA5A5A5A5);

        // Misaligned word load is suppressed but retires
        wr(5'd9, 2'b00, 3'b010, 32'h11); tick();
        wr(5'd9, 2'b01, 3'b010, 32'h2); rs1_addr = 5'd9; #1;
        chk("mis_nobyp", rs1_data, 32'h11);
        tick();
        idle(); #1;
        chk("mis_pulse", 32'(misalign), 32'h1);
        chk("mis_fwd_we", 32'(fwd_we), 32'h0);
        chk("mis_retired", 32'(retired), 32'd9);
        tick();
        chk("mis_clear", 32'(misalign), 32'h0);
        chk("mis_x9", rs1_data, 32'h11);
        // Misaligned halfword (off=1) also suppressed
        wr(5'd9, 2'b01, 3'b101, 32'h1); tick();
        idle(); #1;
        chk("mis_h_pulse", 32'(misalign), 32'h1);
        chk("mis_h_x9", rs1_data, 32'h11);

        // PC+4 select, and select 11 behaving as ALU
        wr(5'd1, 2'b10, 3'b010, 32'h55); pc = 32'h100; pc_plus4 = 32'h104;
        tick();
        wr(5'd2, 2'b11, 3'b010, 32'h77); pc_plus4 = 32'h999; rs2_addr = 5'd2; #1;
        chk("sel11_alu", rs2_data, 32'h77);
        chk("last_pc", last_pc, 32'h100);
        tick();
        idle(); rs1_addr = 5'd1; #1;
        chk("pc4_x1", rs1_data, 32'h104);

        // Back-to-back writes to the same rd
        wr(5'd3, 2'b00, 3'b010, 32'h1); rs1_addr = 5'd3; #1;
        chk("b2b_first", rs1_data, 32'h1); tick();
        wr(5'd3, 2'b00, 3'b010, 32'h2); #1;
        chk("b2b_second", rs1_data, 32'h2); tick();
        idle(); #1;
        chk("b2b_stored", rs1_data, 32'h2);

        // Mid-stream reset with a retiring instruction presented
        wr(5'd4, 2'b00, 3'b010, 32'h9); rst = 1'b1; tick();
        rst = 1'b0; idle(); rs1_addr = 5'd4; #1;
        chk("mid_rst_ret", 32'(retired), 32'h0);
        chk("mid_rst_x4", rs1_data, 32'h0);

        // Counter wrap: 17 retires with idle cycles between
        exp_ret = 0;
        for (int i = 1; i <= 17; i++) begin
            valid = 1'b1; reg_write = 1'b0; tick();
            exp_ret = (exp_ret + 1) % 16;
            chk($sformatf("wrap_v%0d", i), 32'(retired), 32'(exp_ret));
            idle(); tick();
            chk($sformatf("wrap_i%0d", i), 32'(retired), 32'(exp_ret));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
